// File: rtl/keypad_if.sv
// keypad_if: bus-side signals of keypad_scan
// Ports (modport master = keypad_scan side):
//   clear     in   one-cycle pulse zeroing key_data and digit_cnt
//   key_code  out  code of the last accepted key
//   key_valid out  one-cycle pulse per accepted press
//   key_data  out  shifted-in digits, newest in [3:0]
//   digit_cnt out  digits entered since reset/clear, saturates at 8
interface keypad_if;
    logic        clear;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [31:0] key_data;
    logic [3:0]  digit_cnt;
    modport master (input clear, output key_code, key_valid, key_data, digit_cnt);
    modport slave  (output clear, input key_code, key_valid, key_data, digit_cnt);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and hex digit shift register
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   key_col  in   keypad columns, active-low, asynchronous
//   key_row  out  one-hot active-low row drive
//   bus      keypad_if.master: clear in; key_code, key_valid, key_data, digit_cnt out
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    keypad_if.master   bus
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pat_q, pat_d, row_q, row_d, code_q, code_d, dcnt_q, dcnt_d;
    logic          valid_q, valid_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    col_s, code;
    logic [1:0]    r, c;
    logic          tick, accept, rot;
    always_comb begin
        col_s   = sync2_q;
        sync1_d = key_col;
        sync2_d = sync1_q;
        tick    = div_q == DW'(SCAN_DIV - 1);
        div_d   = tick ? '0 : div_q + 1'b1;
        r       = !row_q[0] ? 2'd0 : !row_q[1] ? 2'd1 : !row_q[2] ? 2'd2 : 2'd3;
        c       = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
        code    = {r, c};
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        rot     = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (col_s == 4'hF) rot = 1'b1;
                    else begin
                        pat_d   = col_s;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    // the entry tick already counts as the first stable tick
                    if (col_s != pat_q) state_d = SCAN;
                    else if (int'(cnt_q) + 1 >= DEBOUNCE_TICKS - 1) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end else cnt_d = cnt_q + 1'b1;
                end
                PRESSED: begin
                    if (col_s != 4'hF) cnt_d = '0;
                    else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                        rot     = 1'b1;
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else cnt_d = cnt_q + 1'b1;
                end
                default: state_d = SCAN;
            endcase
        end
        row_d   = rot ? {row_q[2:0], row_q[3]} : row_q;
        code_d  = accept ? code : code_q;
        valid_d = accept;
        // an accept coinciding with clear keeps only the new digit
        data_d  = accept ? {bus.clear ? 28'h0 : data_q[27:0], code} : bus.clear ? 32'h0 : data_q;
        dcnt_d  = accept ? (bus.clear ? 4'd1 : dcnt_q == 4'd8 ? 4'd8 : dcnt_q + 4'd1)
                         : bus.clear ? 4'd0 : dcnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN;
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            div_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= 4'hF;
            row_q   <= 4'b1110;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            dcnt_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            row_q   <= row_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            dcnt_q  <= dcnt_d;
        end
    end
    assign key_row       = row_q;
    assign bus.key_code  = code_q;
    assign bus.key_valid = valid_q;
    assign bus.key_data  = data_q;
    assign bus.digit_cnt = dcnt_q;
endmodule
